bp_be_director_mw: RTL
======================

// Module: bp_be_director_mw
// PURPOSE
// - Multi-issue PC director for the BE checker: tracks expected NPC, checks issue_width_p issue slots per cycle,
//   poisons mispredicted slots, emits FE commands (redirect/fence/fill/attaboy) via an internal cmd FIFO.
// - Sits between issue/dispatch, calculator (br_pkt) and commit (commit_pkt); fe_cmd_o drives the FE.
// PARAMETERS
// - bp_params_p      e_bp_default_cfg  processor config (vaddr_width_p etc. derived)
// - issue_width_p    2                 issue slots checked per cycle (1..4)
// - cmd_fifo_els_p   4                 FE command FIFO depth (>=2)
// - instr_bytes_p    4                 sequential PC stride between slots
// - ctr_width_p      16                perf counter width (only with BP_BE_DIRECTOR_PERF_EN)
// PORTS
// - clk_i           in   1                               clock
// - reset_i         in   1                               synchronous, active-high reset
// - cfg_bus_i       in   cfg_bus_width_lp                config bus (freeze bit)
// - isd_status_i    in   issue_width_p*isd_status_w_lp   per-slot {v, pc, branch_metadata_fwd}; slot 0 oldest
// - expected_npc_o  out  vaddr_width_p                   NPC expected for slot 0
// - poison_isd_o    out  issue_width_p                   per-slot poison
// - suppress_iss_o  out  1                               block issue when not RUN
// - unfreeze_o      out  1                               FREEZE and freeze deasserted
// - irq_waiting_i   in   1                               interrupt pending while WAIT
// - br_pkt_i        in   branch_pkt_width_lp             {v, branch, btaken, npc} from ex1
// - commit_pkt_i    in   commit_pkt_width_lp             commit packet (npc_w_v, npc, event flags)
// - fe_cmd_o        out  fe_cmd_width_lp                 FIFO head
// - fe_cmd_v_o      out  1                               FIFO non-empty
// - fe_cmd_yumi_i   in   1                               FE consumes head (only when fe_cmd_v_o)
// - cmd_empty_n_o / cmd_empty_r_o / cmd_full_n_o / cmd_full_r_o  out 1  FIFO status, next/registered
// BEHAVIOUR
// - Reset: npc_r=0, state=FREEZE, FIFO empty, pending flags 0; fe_cmd_v_o=0, cmd_empty_r_o=1, cmd_full_r_o=0,
//   suppress_iss_o=1, poison_isd_o=0 unless commit npc_w_v.
// - NPC: npc_n = commit.npc_w_v ? commit.npc : br_pkt.npc; written when either valid; commit wins on simultaneity.
//   expected_npc_o = write ? npc_n : npc_r (bypass, 0-cycle).
// - Slot check: exp[0]=expected_npc_o; exp[k]=isd[k-1].pc+instr_bytes_p (mod 2^vaddr_width_p, wraps).
//   mismatch[k]=isd[k].v & (isd[k].pc!=exp[k]); m = lowest mismatching slot.
// - poison_isd_o[k] = commit.npc_w_v | (mismatch exists & k>=m). Invalid slots never cause mismatch.
// - Pending: {btaken,branch} set by br_pkt, cleared by any valid slot (clear over set); last_branch = pending|br_pkt.branch.
// - FSM: FREEZE->(freeze_li? FREEZE : WAIT), freeze_li=cfg.freeze|reset_i; WAIT->FENCE on non-attaboy enqueue;
//   RUN->WAIT on commit.wfi else FENCE on non-attaboy enqueue; FENCE->RUN when cmd_empty_n_o.
// - Enqueue priority (one cmd/cycle): unfreeze(state_reset, vaddr=npc_r) > itlb_fill > sfence > csrw(translation_switch)
//   > wfi > fencei > icache_miss > eret > exception|interrupt|(WAIT&irq_waiting_i)(trap) > mismatch(branch_mispredict,
//   vaddr=exp[m], metadata of slot m; reason from last_branch/btaken only if m==0, else e_not_a_branch)
//   > attaboy (slot 0 valid, no mismatch, last_branch; vaddr=expected_npc_o).
// - FIFO: enqueue iff space; dequeue on yumi; simultaneous enq+deq when full is legal (count unchanged).
//   Attaboy when full: silently dropped. Non-attaboy when full: illegal (assertion fires), command lost.
// - Reset mid-operation flushes FIFO and pending flags in the same cycle; outputs return to reset values next cycle.
// CONFIGURATION
// - BP_BE_DIRECTOR_PERF_EN defined: adds outputs mispredict_cnt_o, attaboy_cnt_o, drop_cnt_o [ctr_width_p];
//   increment on enqueued mispredict / enqueued attaboy / dropped attaboy; wrap at 2^ctr_width_p; reset 0.
// - Undefined: ports and counters absent; functional behaviour identical.
// TESTING
// - Reset, freeze=1 10 cycles then 0 -> unfreeze_o pulses 1 cycle; commit.unfreeze enqueues state_reset vaddr=npc_r.
// - W=2, npc_r=0x1000, slots pc {0x1000,0x1004} -> no poison, no cmd; pc {0x1000,0x1008} -> poison=2'b10, redirect 0x1004.
// - br_pkt taken npc=0x2000, next slot0 pc=0x2000 -> attaboy taken=1; slot0 pc=0x1004 -> mispredict reason incorrect_pred_taken.
// - Same cycle commit.npc_w_v npc=0x3000 and br_pkt.npc=0x4000 -> npc_r=0x3000, poison_isd_o=all 1s.
// - Fill FIFO (depth 4, yumi=0) with attaboys, 5th attaboy -> dropped, cmd_full_r_o=1; with PERF_EN drop_cnt_o=1.
// - RUN, commit.wfi -> e_wait cmd, state WAIT; irq_waiting_i=1 -> trap enqueued, FENCE, RUN once FIFO drains.

Source files
------------

// File: rtl/bp_be_director_mw.sv
// bp_be_director_mw: multi-issue PC director for the backend checker.
// Tracks the expected next PC, checks issue_width_p issue slots per cycle,
// poisons slots from the first mispredicted one onward and sends frontend
// commands (redirect, fence, fill, attaboy) through a small command FIFO.
// Optional build macro: BP_BE_DIRECTOR_PERF_EN adds mispredict/attaboy/drop
// performance counter outputs; functional behaviour is the same either way.
//
// Packed formats (MSB first):
//   isd slot   : {v, pc, branch_metadata_fwd}, slot 0 in the low bits
//   br_pkt     : {v, branch, btaken, npc}
//   commit_pkt : {npc_w_v, npc, unfreeze, itlb_fill, sfence, csrw, wfi,
//                 fencei, icache_miss, eret, exception, interrupt}
//   fe_cmd     : {opcode[2:0], subopcode[1:0], mispredict_reason[1:0],
//                 attaboy_taken, vaddr, branch_metadata_fwd}
//
// state  | meaning
// FREEZE | held by cfg freeze or reset; issue blocked
// WAIT   | waiting (wfi or post-unfreeze) for a redirecting command
// RUN    | normal issue; slots checked against expected NPC
// FENCE  | redirect outstanding; issue blocked until the FIFO drains

module bp_be_director_mw #(
    parameter  int bp_params_p                 = 0,
    parameter  int issue_width_p               = 2,
    parameter  int cmd_fifo_els_p              = 4,
    parameter  int instr_bytes_p               = 4,
    parameter  int ctr_width_p                 = 16,
    localparam int vaddr_width_p               = (bp_params_p == 1) ? 32 : 39,
    localparam int branch_metadata_fwd_width_p = 8,
    localparam int cfg_bus_width_lp            = 1,
    localparam int isd_status_w_lp             = 1 + vaddr_width_p + branch_metadata_fwd_width_p,
    localparam int branch_pkt_width_lp         = 3 + vaddr_width_p,
    localparam int commit_pkt_width_lp         = 11 + vaddr_width_p,
    localparam int fe_cmd_width_lp             = 8 + vaddr_width_p + branch_metadata_fwd_width_p
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [cfg_bus_width_lp-1:0]                cfg_bus_i,
    input  logic [issue_width_p*isd_status_w_lp-1:0]   isd_status_i,
    output logic [vaddr_width_p-1:0]                   expected_npc_o,
    output logic [issue_width_p-1:0]                   poison_isd_o,
    output logic                                       suppress_iss_o,
    output logic                                       unfreeze_o,
    input  logic                                       irq_waiting_i,
    input  logic [branch_pkt_width_lp-1:0]             br_pkt_i,
    input  logic [commit_pkt_width_lp-1:0]             commit_pkt_i,
    output logic [fe_cmd_width_lp-1:0]                 fe_cmd_o,
    output logic                                       fe_cmd_v_o,
    input  logic                                       fe_cmd_yumi_i,
    output logic                                       cmd_empty_n_o,
    output logic                                       cmd_empty_r_o,
    output logic                                       cmd_full_n_o,
    output logic                                       cmd_full_r_o
`ifdef BP_BE_DIRECTOR_PERF_EN
    ,
    output logic [ctr_width_p-1:0]                     mispredict_cnt_o,
    output logic [ctr_width_p-1:0]                     attaboy_cnt_o,
    output logic [ctr_width_p-1:0]                     drop_cnt_o
`endif
);

    localparam int vw_lp     = vaddr_width_p;
    localparam int md_lp     = branch_metadata_fwd_width_p;
    localparam int lg_iw_lp  = (issue_width_p > 1) ? $clog2(issue_width_p) : 1;
    localparam int lg_els_lp = $clog2(cmd_fifo_els_p);
    localparam int cnt_w_lp  = $clog2(cmd_fifo_els_p + 1);

    if (issue_width_p < 1 || issue_width_p > 4 || cmd_fifo_els_p < 2 || ctr_width_p < 1) begin : g_bad_cfg
        $error("bp_be_director_mw: unsupported parameter combination");
    end

    typedef enum logic [1:0] {e_freeze, e_wait, e_run, e_fence} state_e;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence         = 3'd3,
        e_op_wait                 = 3'd4,
        e_op_itlb_fill_response   = 3'd5,
        e_op_itlb_fence           = 3'd6,
        e_op_attaboy              = 3'd7
    } fe_op_e;

    typedef enum logic [1:0] {
        e_subop_branch_mispredict  = 2'd0,
        e_subop_translation_switch = 2'd1,
        e_subop_trap               = 2'd2,
        e_subop_eret               = 2'd3
    } fe_subop_e;

    typedef enum logic [1:0] {
        e_not_a_branch          = 2'd0,
        e_incorrect_pred_taken  = 2'd1,
        e_incorrect_pred_ntaken = 2'd2
    } mispred_e;

    state_e                     r_state, w_state_n;
    logic [vw_lp-1:0]           r_npc;
    logic                       r_pend_branch, r_pend_btaken;

    // Packet fields
    logic                       w_freeze_li;
    logic                       w_br_v, w_br_branch, w_br_btaken;
    logic [vw_lp-1:0]           w_br_npc;
    logic                       w_cm_npc_w_v, w_cm_unfreeze, w_cm_itlb_fill, w_cm_sfence, w_cm_csrw;
    logic                       w_cm_wfi, w_cm_fencei, w_cm_icache_miss, w_cm_eret, w_cm_exception, w_cm_interrupt;
    logic [vw_lp-1:0]           w_cm_npc;

    assign w_freeze_li      = cfg_bus_i[0] | reset_i;
    assign w_br_v           = br_pkt_i[vw_lp+2];
    assign w_br_branch      = br_pkt_i[vw_lp+1];
    assign w_br_btaken      = br_pkt_i[vw_lp];
    assign w_br_npc         = br_pkt_i[vw_lp-1:0];
    assign w_cm_npc_w_v     = commit_pkt_i[vw_lp+10];
    assign w_cm_npc         = commit_pkt_i[vw_lp+9:10];
    assign w_cm_unfreeze    = commit_pkt_i[9];
    assign w_cm_itlb_fill   = commit_pkt_i[8];
    assign w_cm_sfence      = commit_pkt_i[7];
    assign w_cm_csrw        = commit_pkt_i[6];
    assign w_cm_wfi         = commit_pkt_i[5];
    assign w_cm_fencei      = commit_pkt_i[4];
    assign w_cm_icache_miss = commit_pkt_i[3];
    assign w_cm_eret        = commit_pkt_i[2];
    assign w_cm_exception   = commit_pkt_i[1];
    assign w_cm_interrupt   = commit_pkt_i[0];

    // Expected NPC with same-cycle bypass of the incoming update
    logic                       w_npc_write;
    logic [vw_lp-1:0]           w_npc_n;

    assign w_npc_write    = w_cm_npc_w_v | w_br_v;
    assign w_npc_n        = w_cm_npc_w_v ? w_cm_npc : w_br_npc;
    assign expected_npc_o = w_npc_write ? w_npc_n : r_npc;

    logic [issue_width_p-1:0]   w_slot_v;
    logic [vw_lp-1:0]           w_slot_pc [issue_width_p];
    logic [md_lp-1:0]           w_slot_md [issue_width_p];
    logic [vw_lp-1:0]           w_exp     [issue_width_p];
    logic [issue_width_p-1:0]   w_mismatch;
    logic                       w_mis_any;
    logic [lg_iw_lp-1:0]        w_mis_idx;

    // Unpack slots, build per-slot expected PC and find the oldest mismatch
    always_comb begin
        w_mis_any = 1'b0;
        w_mis_idx = '0;
        for (int k = 0; k < issue_width_p; k++) begin
            w_slot_v[k]  = isd_status_i[k*isd_status_w_lp + isd_status_w_lp - 1];
            w_slot_pc[k] = isd_status_i[k*isd_status_w_lp + md_lp +: vw_lp];
            w_slot_md[k] = isd_status_i[k*isd_status_w_lp +: md_lp];
        end
        w_exp[0] = expected_npc_o;
        for (int k = 1; k < issue_width_p; k++) begin
            w_exp[k] = w_slot_pc[k-1] + vw_lp'(instr_bytes_p);
        end
        for (int k = 0; k < issue_width_p; k++) begin
            w_mismatch[k] = w_slot_v[k] & (w_slot_pc[k] != w_exp[k]);
        end
        for (int k = issue_width_p - 1; k >= 0; k--) begin
            if (w_mismatch[k]) begin
                w_mis_any = 1'b1;
                w_mis_idx = lg_iw_lp'(k);
            end
        end
        for (int k = 0; k < issue_width_p; k++) begin
            poison_isd_o[k] = w_cm_npc_w_v | (w_mis_any & (lg_iw_lp'(k) >= w_mis_idx));
        end
    end

    logic w_last_branch, w_last_taken;
    assign w_last_branch = r_pend_branch | (w_br_v & w_br_branch);
    assign w_last_taken  = r_pend_btaken | (w_br_v & w_br_btaken);

    // Command selection: one command per cycle in fixed priority order
    fe_op_e                     w_cmd_op;
    fe_subop_e                  w_cmd_subop;
    mispred_e                   w_cmd_reason;
    logic                       w_cmd_v, w_cmd_attaboy, w_cmd_taken;
    logic [vw_lp-1:0]           w_cmd_vaddr;
    logic [md_lp-1:0]           w_cmd_md;
    logic [fe_cmd_width_lp-1:0] w_cmd;

    always_comb begin
        w_cmd_v       = 1'b0;
        w_cmd_attaboy = 1'b0;
        w_cmd_op      = e_op_attaboy;
        w_cmd_subop   = e_subop_branch_mispredict;
        w_cmd_reason  = e_not_a_branch;
        w_cmd_taken   = 1'b0;
        w_cmd_vaddr   = expected_npc_o;
        w_cmd_md      = '0;
        if (w_cm_unfreeze) begin
            w_cmd_v     = 1'b1;
            w_cmd_op    = e_op_state_reset;
            w_cmd_vaddr = r_npc;
        end else if (w_cm_itlb_fill) begin
            w_cmd_v  = 1'b1;
            w_cmd_op = e_op_itlb_fill_response;
        end else if (w_cm_sfence) begin
            w_cmd_v  = 1'b1;
            w_cmd_op = e_op_itlb_fence;
        end else if (w_cm_csrw) begin
            w_cmd_v     = 1'b1;
            w_cmd_op    = e_op_pc_redirection;
            w_cmd_subop = e_subop_translation_switch;
        end else if (w_cm_wfi) begin
            w_cmd_v  = 1'b1;
            w_cmd_op = e_op_wait;
        end else if (w_cm_fencei) begin
            w_cmd_v  = 1'b1;
            w_cmd_op = e_op_icache_fence;
        end else if (w_cm_icache_miss) begin
            w_cmd_v  = 1'b1;
            w_cmd_op = e_op_icache_fill_response;
        end else if (w_cm_eret) begin
            w_cmd_v     = 1'b1;
            w_cmd_op    = e_op_pc_redirection;
            w_cmd_subop = e_subop_eret;
        end else if (w_cm_exception | w_cm_interrupt | ((r_state == e_wait) & irq_waiting_i)) begin
            w_cmd_v     = 1'b1;
            w_cmd_op    = e_op_pc_redirection;
            w_cmd_subop = e_subop_trap;
        end else if (w_mis_any) begin
            w_cmd_v     = 1'b1;
            w_cmd_op    = e_op_pc_redirection;
            w_cmd_subop = e_subop_branch_mispredict;
            w_cmd_vaddr = w_exp[w_mis_idx];
            w_cmd_md    = w_slot_md[w_mis_idx];
            // Only slot 0 can be blamed on the last resolved branch
            if ((w_mis_idx == '0) && w_last_branch) begin
                w_cmd_reason = w_last_taken ? e_incorrect_pred_taken : e_incorrect_pred_ntaken;
            end
        end else if (w_slot_v[0] & w_last_branch) begin
            w_cmd_v       = 1'b1;
            w_cmd_attaboy = 1'b1;
            w_cmd_op      = e_op_attaboy;
            w_cmd_taken   = w_last_taken;
            w_cmd_md      = w_slot_md[0];
        end
    end

    assign w_cmd = {w_cmd_op, w_cmd_subop, w_cmd_reason, w_cmd_taken, w_cmd_vaddr, w_cmd_md};

    // FIFO control
    logic [fe_cmd_width_lp-1:0] r_mem [cmd_fifo_els_p];
    logic [lg_els_lp-1:0]       r_wptr, r_rptr;
    logic [cnt_w_lp-1:0]        r_count, w_count_n;
    logic                       w_deq, w_space, w_enq;

    assign fe_cmd_v_o = ~cmd_empty_r_o;
    assign fe_cmd_o   = r_mem[r_rptr];
    assign w_deq      = fe_cmd_yumi_i & fe_cmd_v_o;
    assign w_space    = ~cmd_full_r_o | w_deq;
    assign w_enq      = w_cmd_v & w_space;

    // Next occupancy; forced empty under reset so the *_n flags follow
    always_comb begin
        w_count_n = r_count;
        if (w_enq & ~w_deq) begin
            w_count_n = r_count + cnt_w_lp'(1);
        end else if (~w_enq & w_deq) begin
            w_count_n = r_count - cnt_w_lp'(1);
        end
        if (reset_i) begin
            w_count_n = '0;
        end
    end

    assign cmd_empty_n_o = (w_count_n == '0);
    assign cmd_full_n_o  = (w_count_n == cnt_w_lp'(cmd_fifo_els_p));

    // FIFO pointers, occupancy and registered status
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            cmd_empty_r_o <= 1'b1;
            cmd_full_r_o  <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= (r_wptr == lg_els_lp'(cmd_fifo_els_p - 1)) ? '0 : r_wptr + lg_els_lp'(1);
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == lg_els_lp'(cmd_fifo_els_p - 1)) ? '0 : r_rptr + lg_els_lp'(1);
            end
            r_count       <= w_count_n;
            cmd_empty_r_o <= cmd_empty_n_o;
            cmd_full_r_o  <= cmd_full_n_o;
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (w_enq && !reset_i) begin
            r_mem[r_wptr] <= w_cmd;
        end
    end

    // A redirecting command arriving with no room would be lost
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(w_cmd_v && !w_cmd_attaboy && !w_space))
                else $error("bp_be_director_mw: non-attaboy command with FIFO full");
        end
    end

    // Expected NPC and pending branch flags (a valid slot consumes them)
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_npc         <= '0;
            r_pend_branch <= 1'b0;
            r_pend_btaken <= 1'b0;
        end else begin
            if (w_npc_write) begin
                r_npc <= w_npc_n;
            end
            if (|w_slot_v) begin
                r_pend_branch <= 1'b0;
                r_pend_btaken <= 1'b0;
            end else if (w_br_v) begin
                r_pend_branch <= w_br_branch;
                r_pend_btaken <= w_br_btaken;
            end
        end
    end

    // FSM next state
    logic w_redirect_req;
    assign w_redirect_req = w_cmd_v & ~w_cmd_attaboy;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_freeze: if (!w_freeze_li)   w_state_n = e_wait;
            e_wait:   if (w_redirect_req) w_state_n = e_fence;
            e_run: begin
                if (w_cm_wfi)            w_state_n = e_wait;
                else if (w_redirect_req) w_state_n = e_fence;
            end
            e_fence:  if (cmd_empty_n_o)  w_state_n = e_run;
            default:                      w_state_n = e_freeze;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_freeze;
        end else begin
            r_state <= w_state_n;
        end
    end

    assign suppress_iss_o = (r_state != e_run);
    assign unfreeze_o     = (r_state == e_freeze) & ~w_freeze_li;

`ifdef BP_BE_DIRECTOR_PERF_EN
    logic w_enq_mispred, w_drop;
    assign w_enq_mispred = w_enq & (w_cmd_op == e_op_pc_redirection) & (w_cmd_subop == e_subop_branch_mispredict);
    assign w_drop        = w_cmd_v & w_cmd_attaboy & ~w_space;

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mispredict_cnt_o <= '0;
            attaboy_cnt_o    <= '0;
            drop_cnt_o       <= '0;
        end else begin
            if (w_enq_mispred)          mispredict_cnt_o <= mispredict_cnt_o + ctr_width_p'(1);
            if (w_enq & w_cmd_attaboy)  attaboy_cnt_o    <= attaboy_cnt_o + ctr_width_p'(1);
            if (w_drop)                 drop_cnt_o       <= drop_cnt_o + ctr_width_p'(1);
        end
    end
`endif

endmodule
